// File: rtl/conv1_mem_write.sv
// conv1_mem_write
// Write-side addresser for the Convolution 1 output memory. It accepts the
// conv1 result stream and issues raster-order write addresses over a
// IMG_W x IMG_H feature map, one map per bank. It also flags each completed
// map and the completed image so the pooling-side reader can start.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-low reset
//   start     arm for a new image (honoured only in IDLE or DONE)
//   in_valid  conv engine presents a pixel on in_data
//   in_data   conv1 result pixel (signed)
//   in_ready  block accepts in_data this cycle (high only while writing)
//   we        memory write enable (one cycle after each accepted beat)
//   waddr     write address within the current bank
//   wdata     write data (ReLU-clamped when RELU != 0)
//   map_sel   bank index of the current write
//   map_done  pulse coincident with the last write of each map
//   done      level, set once all NUM_MAPS maps have been written
module conv1_mem_write #(
  parameter int IMG_W    = 24,
  parameter int IMG_H    = 24,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int NUM_MAPS = 6,
  parameter int RELU     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [2:0]        map_sel,
  output logic              map_done,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [4:0] COL_LAST = 5'(IMG_W - 1);
  localparam logic [4:0] ROW_LAST = 5'(IMG_H - 1);
  localparam logic [2:0] MAP_LAST = 3'(NUM_MAPS - 1);
  localparam bit         RELU_EN  = (RELU != 0);

  state_t              state;
  state_t              state_next;
  logic [4:0]          col;
  logic [4:0]          row;
  logic [ADDR_W-1:0]   addr;
  logic [2:0]          map;
  logic                accept;
  logic                last_col;
  logic                last_pix;
  logic                clear_cnt;
  logic [DATA_W-1:0]   pix;

  assign in_ready = (state == S_WRITE);
  assign accept   = in_valid && in_ready;
  assign last_col = (col == COL_LAST);
  assign last_pix = last_col && (row == ROW_LAST);
  // Counters restart whenever a new image is armed from IDLE or DONE.
  assign clear_cnt = start && (state != S_WRITE);
  assign pix = (RELU_EN && in_data[DATA_W-1]) ? '0 : in_data;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_WRITE;
      S_WRITE: if (accept && last_pix && (map == MAP_LAST)) state_next = S_DONE;
      S_DONE:  if (start) state_next = S_WRITE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      col      <= '0;
      row      <= '0;
      addr     <= '0;
      map      <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      map_sel  <= '0;
      map_done <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      we       <= accept;
      map_done <= accept && last_pix;
      // done trails the final write by one cycle; start in DONE drops it at
      // the same edge that re-enters WRITE.
      done     <= (state == S_DONE) && !start;

      if (accept) begin
        waddr   <= addr;
        wdata   <= pix;
        map_sel <= map;
        if (last_pix) begin
          col  <= '0;
          row  <= '0;
          addr <= '0;
          map  <= map + 3'd1;
        end else if (last_col) begin
          col  <= '0;
          row  <= row + 5'd1;
          addr <= addr + ADDR_W'(1);
        end else begin
          col  <= col + 5'd1;
          addr <= addr + ADDR_W'(1);
        end
      end else if (clear_cnt) begin
        col  <= '0;
        row  <= '0;
        addr <= '0;
        map  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_conv1_mem_write.sv
// tb_conv1_mem_write
// Self-checking bench for conv1_mem_write. Two instances share the stimulus:
// one with ReLU clamping, one passing data unchanged. Expected values come
// from a per-image beat-count model plus a short table of hand vectors.
module tb_conv1_mem_write;

  localparam int PIX   = 24 * 24;
  localparam int MAPS  = 6;
  localparam int TOTAL = PIX * MAPS;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;

  logic        in_ready,  we,  map_done,  done;
  logic [9:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  map_sel;

  logic        in_ready_n, we_n, map_done_n, done_n;
  logic [9:0]  waddr_n;
  logic [15:0] wdata_n;
  logic [2:0]  map_sel_n;

  int n_checks = 0;
  int n_errors = 0;
  int md_count = 0;
  int md_next_map = 0;

  always #5 clk = ~clk;

  conv1_mem_write #(.RELU(1)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .we(we), .waddr(waddr),
    .wdata(wdata), .map_sel(map_sel), .map_done(map_done), .done(done)
  );

  conv1_mem_write #(.RELU(0)) dut_nr (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready_n), .we(we_n), .waddr(waddr_n),
    .wdata(wdata_n), .map_sel(map_sel_n), .map_done(map_done_n), .done(done_n)
  );

  // Reference model: an image is a flat sequence of TOTAL beats; beat k lands
  // at address k % PIX of bank k / PIX.
  bit          m_armed    = 1'b0;
  bit          m_finished = 1'b0;
  int          m_beats    = 0;
  logic        e_we = 1'b0, e_map_done = 1'b0, e_done = 1'b0;
  logic [9:0]  e_waddr = '0;
  logic [15:0] e_wdata = '0, e_wdata_nr = '0;
  logic [2:0]  e_map_sel = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic v, input logic [15:0] d, input logic s, input logic r);
    if (!r) begin
      m_armed = 0; m_finished = 0; m_beats = 0;
      e_we = 0; e_map_done = 0; e_done = 0;
      e_waddr = '0; e_wdata = '0; e_wdata_nr = '0; e_map_sel = '0;
    end else begin
      e_we       = 0;
      e_map_done = 0;
      e_done     = m_finished && !s;
      if (m_armed && v) begin
        e_we       = 1;
        e_waddr    = 10'(m_beats % PIX);
        e_map_sel  = 3'(m_beats / PIX);
        e_wdata    = d[15] ? 16'h0000 : d;
        e_wdata_nr = d;
        e_map_done = ((m_beats % PIX) == PIX - 1);
        m_beats++;
        if (m_beats == TOTAL) begin
          m_armed    = 0;
          m_finished = 1;
        end
      end else if (!m_armed && s) begin
        m_armed    = 1;
        m_finished = 0;
        m_beats    = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("in_ready", 32'(in_ready), 32'(m_armed));
    check("we",       32'(we),       32'(e_we));
    check("waddr",    32'(waddr),    32'(e_waddr));
    check("wdata",    32'(wdata),    32'(e_wdata));
    check("map_sel",  32'(map_sel),  32'(e_map_sel));
    check("map_done", 32'(map_done), 32'(e_map_done));
    check("done",     32'(done),     32'(e_done));
    check("nr_we",    32'(we_n),     32'(e_we));
    check("nr_waddr", 32'(waddr_n),  32'(e_waddr));
    check("nr_wdata", 32'(wdata_n),  32'(e_wdata_nr));
    check("nr_ready", 32'(in_ready_n), 32'(m_armed));
    check("nr_done",  32'(done_n),   32'(e_done));
    if (map_done === 1'b1) begin
      check("md_map_order", 32'(map_sel), 32'(md_next_map));
      check("md_at_575",    32'(waddr),   32'(PIX - 1));
      md_count++;
      md_next_map++;
    end
  endtask

  // Drive inputs between edges, let the edge happen, then compare mid-cycle.
  task automatic cycle(input logic v, input logic [15:0] d, input logic s, input logic r);
    in_valid = v; in_data = d; start = s; reset = r;
    @(posedge clk);
    model_update(v, d, s, r);
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    logic        r, s, v;
    logic [15:0] d;
    logic        e_ready, e_we;
    logic [9:0]  e_waddr;
    logic [15:0] e_wdata, e_wdata_nr;
    logic [2:0]  e_map;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int guard;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;

    //          r  s  v  d        rdy we waddr wdata    wdata_nr map
    tbl[0]  = '{0, 0, 0, 16'h0000, 0, 0, 10'd0, 16'h0000, 16'h0000, 3'd0};
    tbl[1]  = '{1, 1, 0, 16'h0000, 1, 0, 10'd0, 16'h0000, 16'h0000, 3'd0};
    tbl[2]  = '{1, 0, 1, 16'h0005, 1, 1, 10'd0, 16'h0005, 16'h0005, 3'd0};
    tbl[3]  = '{1, 0, 0, 16'h0000, 1, 0, 10'd0, 16'h0005, 16'h0005, 3'd0};
    tbl[4]  = '{1, 0, 1, 16'h0007, 1, 1, 10'd1, 16'h0007, 16'h0007, 3'd0};
    tbl[5]  = '{1, 0, 0, 16'h0000, 1, 0, 10'd1, 16'h0007, 16'h0007, 3'd0};
    tbl[6]  = '{1, 0, 1, 16'hFFF0, 1, 1, 10'd2, 16'h0000, 16'hFFF0, 3'd0};
    tbl[7]  = '{1, 0, 1, 16'h0012, 1, 1, 10'd3, 16'h0012, 16'h0012, 3'd0};
    tbl[8]  = '{1, 1, 0, 16'h0000, 1, 0, 10'd3, 16'h0012, 16'h0012, 3'd0};
    tbl[9]  = '{1, 0, 1, 16'h8000, 1, 1, 10'd4, 16'h0000, 16'h8000, 3'd0};
    tbl[10] = '{1, 0, 1, 16'h7FFF, 1, 1, 10'd5, 16'h7FFF, 16'h7FFF, 3'd0};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].r);
      check($sformatf("tbl%0d_ready", i),    32'(in_ready), 32'(tbl[i].e_ready));
      check($sformatf("tbl%0d_we", i),       32'(we),       32'(tbl[i].e_we));
      check($sformatf("tbl%0d_waddr", i),    32'(waddr),    32'(tbl[i].e_waddr));
      check($sformatf("tbl%0d_wdata", i),    32'(wdata),    32'(tbl[i].e_wdata));
      check($sformatf("tbl%0d_wdata_nr", i), 32'(wdata_n),  32'(tbl[i].e_wdata_nr));
      check($sformatf("tbl%0d_map", i),      32'(map_sel),  32'(tbl[i].e_map));
    end

    // Full image: map 0 with back-to-back beats carrying their index.
    cycle(0, 16'h0, 0, 0);
    md_count = 0; md_next_map = 0;
    cycle(0, 16'h0, 1, 1);
    for (int k = 0; k < PIX; k++) cycle(1, 16'(k), 0, 1);
    check("map0_last_waddr", 32'(waddr), 32'(PIX - 1));
    check("map0_done_pulse", 32'(map_done), 32'd1);

    // Map 1: start pulsed alongside the beat at address 100 is ignored.
    for (int k = 0; k < 100; k++) cycle(1, 16'($urandom), 0, 1);
    cycle(1, 16'($urandom), 1, 1);
    check("start_mid_waddr100", 32'(waddr), 32'd100);
    check("start_mid_map1", 32'(map_sel), 32'd1);
    cycle(1, 16'($urandom), 0, 1);
    check("start_ignored_waddr101", 32'(waddr), 32'd101);

    // Rest of the image with random gaps and data.
    guard = 0;
    while (m_armed && guard < 20000) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 0, 1);
      guard++;
    end
    check("image_finished_in_budget", 32'(m_armed), 32'd0);
    check("final_we", 32'(we), 32'd1);
    check("done_not_yet", 32'(done), 32'd0);
    for (int k = 0; k < 3; k++) cycle(1, 16'($urandom), 0, 1);
    check("done_level", 32'(done), 32'd1);
    check("done_ready_low", 32'(in_ready), 32'd0);
    check("six_map_done", 32'(md_count), 32'd6);

    // Restart from DONE, then reset 300 beats into map 2.
    md_next_map = 0;
    cycle(0, 16'h0, 1, 1);
    check("restart_done_clear", 32'(done), 32'd0);
    cycle(1, 16'h0042, 0, 1);
    check("restart_waddr0", 32'(waddr), 32'd0);
    check("restart_map0", 32'(map_sel), 32'd0);
    guard = 0;
    while (m_beats < 2 * PIX + 300 && guard < 20000) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 0, 1);
      guard++;
    end
    check("map2_reached", 32'(m_beats), 32'(2 * PIX + 300));
    check("pre_reset_map2", 32'(map_sel), 32'd2);
    cycle(1, 16'h1234, 0, 0);
    check("reset_we0", 32'(we), 32'd0);
    check("reset_waddr0", 32'(waddr), 32'd0);
    check("reset_map0", 32'(map_sel), 32'd0);
    check("reset_idle_ready0", 32'(in_ready), 32'd0);
    cycle(1, 16'h1111, 0, 1);
    check("idle_ignores_valid", 32'(we), 32'd0);
    md_next_map = 0;
    cycle(0, 16'h0, 1, 1);
    for (int k = 0; k < 3; k++) cycle(1, 16'(k + 9), 0, 1);
    check("after_reset_waddr2", 32'(waddr), 32'd2);
    check("after_reset_map0", 32'(map_sel), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
